// File: rtl/pluse_sync_pkg.sv
// pluse_sync_pkg: shared types, limits and edge-detect helper for the pulse synchronizer.
package pluse_sync_pkg;

    typedef enum logic [1:0] {
        EDGE_TOGGLE = 2'd0,
        EDGE_RISE   = 2'd1,
        EDGE_FALL   = 2'd2
    } edge_mode_e;

    localparam int SYNC_STAGES_MIN = 2;

    function automatic logic edge_detect(edge_mode_e mode, logic cur, logic prev);
        return mode == EDGE_RISE ? (cur & ~prev) :
               mode == EDGE_FALL ? (~cur & prev) : (cur ^ prev);
    endfunction

endpackage

// File: rtl/pluse_sync_rx_sync_cell.sv
// sync_cell: single-bit multi-flop synchronizer, async active-low reset to 0.
module sync_cell #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] s_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) s_q <= '0;
        else         s_q <= {s_q[STAGES-2:0], d_i};
    end

    assign q_o = s_q[STAGES-1];

endmodule

// File: rtl/pluse_sync_rx.sv
// pluse_sync_rx: multi-channel async event receiver; synchronizes, edge-detects and
// re-issues events as single-cycle pulses gated by ready, with saturating pending counts.
module pluse_sync_rx
    import pluse_sync_pkg::*;
#(
    parameter int         CH          = 4,
    parameter int         SYNC_STAGES = 2,
    parameter int         CNT_W       = 3,
    parameter edge_mode_e MODE        = EDGE_TOGGLE
) (
    input  logic                  des_clk,
    input  logic                  des_rstn,
    input  logic [CH-1:0]         s_evt,
    input  logic [CH-1:0]         des_ready,
    input  logic [CH-1:0]         ovf_clr,
    output logic [CH-1:0]         des_pluse,
    output logic [CH*CNT_W-1:0]   pend_cnt,
    output logic [CH-1:0]         ovf
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || CNT_W < 1 || CH < 1) begin : g_param_chk
        $error("pluse_sync_rx: invalid CH/SYNC_STAGES/CNT_W");
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic             sync_s, dly_q, pls_q, ovf_q, ovf_d;
        logic             evt, sat, avail, issue, ovf_set;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        sync_cell #(.STAGES(SYNC_STAGES)) u_sync (
            .clk_i  (des_clk),
            .rst_ni (des_rstn),
            .d_i    (s_evt[i]),
            .q_o    (sync_s)
        );

        assign evt     = edge_detect(MODE, sync_s, dly_q);
        assign sat     = &cnt_q;
        assign avail   = evt | (|cnt_q);
        assign issue   = des_ready[i] & avail;
        assign ovf_set = evt & ~issue & sat;
        // a set in the same cycle as a clear must win
        assign ovf_d   = ovf_set | (ovf_q & ~ovf_clr[i]);

        // evt & issue leaves the count alone: the new event replaces the consumed one
        always_comb begin
            cnt_d = (evt & ~issue & ~sat) ? cnt_q + CNT_W'(1) :
                    (~evt & issue)        ? cnt_q - CNT_W'(1) : cnt_q;
        end

        always_ff @(posedge des_clk or negedge des_rstn) begin
            if (!des_rstn) begin
                dly_q <= 1'b0;
                pls_q <= 1'b0;
                ovf_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                dly_q <= sync_s;
                pls_q <= issue;
                ovf_q <= ovf_d;
                cnt_q <= cnt_d;
            end
        end

        assign des_pluse[i]                 = pls_q;
        assign pend_cnt[i*CNT_W +: CNT_W]   = cnt_q;
        assign ovf[i]                       = ovf_q;
    end

endmodule

// File: tb/tb_pluse_sync_rx.sv
// tb_pluse_sync_rx: directed bench driving toggle/rise/fall builds in parallel against a count-level model.
module tb_pluse_sync_rx;
    import pluse_sync_pkg::*;

    localparam int CH   = 4;
    localparam int S    = 2;
    localparam int W    = 3;
    localparam int MAXC = (1 << W) - 1;

    logic          des_clk  = 1'b0;
    logic          des_rstn = 1'b0;
    logic [CH-1:0] s_evt    = '0;
    logic [CH-1:0] des_ready = '1;
    logic [CH-1:0] ovf_clr  = '0;

    logic [CH-1:0]   pls  [3];
    logic [CH*W-1:0] pnd  [3];
    logic [CH-1:0]   ovfo [3];

    int nvec = 0;
    int errs = 0;
    int pcnt [3][CH];
    int base [3][CH];

    edge_mode_e modes [3] = '{EDGE_TOGGLE, EDGE_RISE, EDGE_FALL};

    always #5 des_clk = ~des_clk;

    pluse_sync_rx #(.CH(CH), .SYNC_STAGES(S), .CNT_W(W), .MODE(EDGE_TOGGLE)) u_tog (
        .des_clk(des_clk), .des_rstn(des_rstn), .s_evt(s_evt), .des_ready(des_ready),
        .ovf_clr(ovf_clr), .des_pluse(pls[0]), .pend_cnt(pnd[0]), .ovf(ovfo[0]));
    pluse_sync_rx #(.CH(CH), .SYNC_STAGES(S), .CNT_W(W), .MODE(EDGE_RISE)) u_rise (
        .des_clk(des_clk), .des_rstn(des_rstn), .s_evt(s_evt), .des_ready(des_ready),
        .ovf_clr(ovf_clr), .des_pluse(pls[1]), .pend_cnt(pnd[1]), .ovf(ovfo[1]));
    pluse_sync_rx #(.CH(CH), .SYNC_STAGES(S), .CNT_W(W), .MODE(EDGE_FALL)) u_fall (
        .des_clk(des_clk), .des_rstn(des_rstn), .s_evt(s_evt), .des_ready(des_ready),
        .ovf_clr(ovf_clr), .des_pluse(pls[2]), .pend_cnt(pnd[2]), .ovf(ovfo[2]));

    // Model: an input edge sampled at clock k is seen as an event S edges later and
    // spent at that edge if ready, otherwise banked in a saturating count.
    logic [CH-1:0] hist [0:S] = '{default: '0};
    int m_pend [3][CH];
    bit m_ovf  [3][CH];
    bit m_pls  [3][CH];

    always @(posedge des_clk or negedge des_rstn) begin
        bit cur, prev, ev, iss;
        if (!des_rstn) begin
            for (int k = 0; k <= S; k++) hist[k] = '0;
            for (int m = 0; m < 3; m++)
                for (int c = 0; c < CH; c++) begin
                    m_pend[m][c] = 0;
                    m_ovf[m][c]  = 0;
                    m_pls[m][c]  = 0;
                end
        end else begin
            for (int m = 0; m < 3; m++)
                for (int c = 0; c < CH; c++) begin
                    cur  = hist[S-1][c];
                    prev = hist[S][c];
                    ev   = (modes[m] == EDGE_TOGGLE) ? (cur != prev) :
                           (modes[m] == EDGE_RISE)   ? (cur && !prev) : (!cur && prev);
                    iss  = des_ready[c] && (ev || m_pend[m][c] > 0);
                    m_pls[m][c] = iss;
                    if (ev && !iss) begin
                        if (m_pend[m][c] == MAXC) m_ovf[m][c] = 1;
                        else m_pend[m][c]++;
                    end else begin
                        if (!ev && iss) m_pend[m][c]--;
                        if (ovf_clr[c]) m_ovf[m][c] = 0;
                    end
                end
            for (int k = S; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = s_evt;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        for (int m = 0; m < 3; m++)
            for (int c = 0; c < CH; c++) begin
                chk($sformatf("u%0d_pls%0d", m, c), 32'(pls[m][c]), 32'(m_pls[m][c]));
                chk($sformatf("u%0d_pend%0d", m, c), 32'(pnd[m][c*W +: W]), m_pend[m][c]);
                chk($sformatf("u%0d_ovf%0d", m, c), 32'(ovfo[m][c]), 32'(m_ovf[m][c]));
                pcnt[m][c] += int'(pls[m][c]);
            end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge des_clk);
            #1 cmp_all();
            @(negedge des_clk);
        end
    endtask

    task automatic snap();
        for (int m = 0; m < 3; m++)
            for (int c = 0; c < CH; c++) base[m][c] = pcnt[m][c];
    endtask

    function automatic int delta(input int m, input int c);
        return pcnt[m][c] - base[m][c];
    endfunction

    initial begin
        int tot;
        for (int m = 0; m < 3; m++)
            for (int c = 0; c < CH; c++) pcnt[m][c] = 0;
        step(2);
        chk("rst_pls", 32'(pls[0]), 0);
        chk("rst_pend", 32'(pnd[0]), 0);
        chk("rst_ovf", 32'(ovfo[0]), 0);
        des_rstn = 1'b1;
        step(2);

        // single rising event on ch0: pulse after the third edge from capture
        snap();
        s_evt[0] = 1'b1;
        step(); chk("t1_e0", 32'(pls[0][0]), 0);
        step(); chk("t1_e1", 32'(pls[0][0]), 0);
        step(); chk("t1_e2", 32'(pls[0][0]), 1);
        chk("t1_quiet", 32'(pls[0][3:1]), 0);
        chk("t1_rise", 32'(pls[1][0]), 1);
        chk("t1_fall", 32'(pls[2][0]), 0);
        step(); chk("t1_e3", 32'(pls[0][0]), 0);
        chk("t1_pend", 32'(pnd[0]), 0);
        step(3);
        s_evt[0] = 1'b0;
        step(6);
        chk("t1_tog_n", delta(0, 0), 2);
        chk("t1_rise_n", delta(1, 0), 1);
        chk("t1_fall_n", delta(2, 0), 1);

        // ch1 up then down, 4 cycles apart
        snap();
        s_evt[1] = 1'b1; step(4);
        s_evt[1] = 1'b0; step(6);
        chk("t2_tog_n", delta(0, 1), 2);
        chk("t2_rise_n", delta(1, 1), 1);
        chk("t2_fall_n", delta(2, 1), 1);

        // ch2 backpressured: three events bank, then drain back-to-back
        snap();
        des_ready[2] = 1'b0;
        s_evt[2] = 1'b1; step(4);
        s_evt[2] = 1'b0; step(4);
        s_evt[2] = 1'b1; step(4);
        chk("t3_pend", 32'(pnd[0][2*W +: W]), 3);
        chk("t3_rise_pend", 32'(pnd[1][2*W +: W]), 2);
        chk("t3_none", delta(0, 2), 0);
        des_ready[2] = 1'b1;
        step(); chk("t3_d1_pls", 32'(pls[0][2]), 1); chk("t3_d1_pend", 32'(pnd[0][2*W +: W]), 2);
        step(); chk("t3_d2_pls", 32'(pls[0][2]), 1); chk("t3_d2_pend", 32'(pnd[0][2*W +: W]), 1);
        step(); chk("t3_d3_pls", 32'(pls[0][2]), 1); chk("t3_d3_pend", 32'(pnd[0][2*W +: W]), 0);
        step(); chk("t3_d4_pls", 32'(pls[0][2]), 0);

        // ch3 saturation and overflow
        des_ready[3] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_evt[3] = ~s_evt[3];
            step(4);
        end
        chk("t4_sat", 32'(pnd[0][3*W +: W]), 7);
        chk("t4_no_ovf", 32'(ovfo[0][3]), 0);
        s_evt[3] = ~s_evt[3];
        step(4);
        chk("t4_sat8", 32'(pnd[0][3*W +: W]), 7);
        chk("t4_ovf", 32'(ovfo[0][3]), 1);
        ovf_clr[3] = 1'b1; step(); ovf_clr[3] = 1'b0;
        chk("t4_clr", 32'(ovfo[0][3]), 0);
        step(2);
        s_evt[3] = ~s_evt[3];
        step(2);
        ovf_clr[3] = 1'b1; step(); ovf_clr[3] = 1'b0;
        chk("t4_set_wins", 32'(ovfo[0][3]), 1);
        step(2);

        // ch0: new event arrives on the same edge a banked one is issued
        des_ready[0] = 1'b0;
        s_evt[0] = ~s_evt[0]; step(4);
        s_evt[0] = ~s_evt[0]; step(4);
        chk("t5_pend2", 32'(pnd[0][0 +: W]), 2);
        snap();
        s_evt[0] = ~s_evt[0];
        step(2);
        des_ready[0] = 1'b1;
        step();
        chk("t5_same_pend", 32'(pnd[0][0 +: W]), 2);
        chk("t5_same_pls", 32'(pls[0][0]), 1);
        step(4);
        chk("t5_total", delta(0, 0), 3);
        chk("t5_pend0", 32'(pnd[0][0 +: W]), 0);

        // async reset in the middle of draining ch3
        des_ready[3] = 1'b1;
        step(2);
        chk("t6_pend5", 32'(pnd[0][3*W +: W]), 5);
        chk("t6_pls_pre", 32'(pls[0][3]), 1);
        #2 des_rstn = 1'b0;
        #1;
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("t6_pls_u%0d", m), 32'(pls[m]), 0);
            chk($sformatf("t6_pend_u%0d", m), 32'(pnd[m]), 0);
            chk($sformatf("t6_ovf_u%0d", m), 32'(ovfo[m]), 0);
        end
        s_evt = '0;
        @(negedge des_clk);
        step(2);
        des_rstn = 1'b1;
        snap();
        step(10);
        tot = 0;
        for (int m = 0; m < 3; m++)
            for (int c = 0; c < CH; c++) tot += delta(m, c);
        chk("t6_silent", tot, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule

// File: doc/pluse_sync_rx.md
# pluse_sync_rx

Destination-side multi-channel pulse synchronizer: receives CH asynchronous event lines from foreign clock domains, synchronizes each through a configurable flop chain, detects events per a selectable edge mode, and re-issues them as single-cycle pulses in the destination domain. Unlike the two-clock single-channel pulse synchronizer, it has a per-channel ready back-pressure input and a saturating pending-event counter, so bursts are queued rather than lost, and an overflow is flagged. It sits at the destination clock boundary of any block receiving toggles or level events from other domains.

## Interface
- CH, 4, number of independent channels (≥1)
- SYNC_STAGES, 2, synchronizer flop depth (≥2)
- CNT_W, 3, pending-counter width; max pending = 2^CNT_W−1
- MODE, EDGE_TOGGLE, event definition for all channels (edge_mode_e: EDGE_TOGGLE, EDGE_RISE, EDGE_FALL)

- des_clk  input  1  destination clock; only clock in the block
- des_rstn  input  1  asynchronous active-low reset
- s_evt  input  CH  asynchronous event lines, one per channel, from foreign domains
- des_ready  input  CH  per-channel consumer ready; pulse issued only when high
- ovf_clr  input  CH  per-channel synchronous clear of sticky overflow
- des_pluse  output  CH  single-cycle event pulse per channel
- pend_cnt  output  CH*CNT_W  per-channel pending count; channel i at [i*CNT_W +: CNT_W]
- ovf  output  CH  per-channel sticky overflow flag

## Operation
- Reset: all sync flops, edge-delay flops, pend_cnt, des_pluse and ovf are 0. Sources must hold s_evt at 0 through reset release; in EDGE_TOGGLE/EDGE_RISE a line high at release yields one event.
- Per channel: chain s[0..SYNC_STAGES−1], delay flop d <= s[last]. evt = s[last]^d (TOGGLE), s[last]&~d (RISE), ~s[last]&d (FALL).
- avail = evt | (pend_cnt≠0). issue = des_ready & avail. des_pluse <= issue.
- Counter update per cycle:
  - evt & ~issue: pend_cnt+1, if not saturated.
  - ~evt & issue & pend_cnt≠0: pend_cnt−1.
  - evt & issue: unchanged; the new event replaces the one consumed.
  - evt & ~issue & pend_cnt = max: event dropped, ovf <= 1, pend_cnt stays max.
- ovf: set as above; cleared by ovf_clr only when no set occurs in the same cycle; set wins.
- Issue is FIFO-equivalent by count only; events carry no payload.
- Channels are fully independent; no cross-channel ordering guaranteed.

## Timing
- Event edge on s_evt settled before des_clk edge E0 (captured in s[0]): evt asserts after E_{SYNC_STAGES−1}; with des_ready=1 and pend_cnt=0, des_pluse is high for exactly one cycle after E_{SYNC_STAGES}.
- Latency for SYNC_STAGES=2: des_pluse high after the 3rd des_clk edge counted from capture.
- des_ready held high: at most one pulse per cycle; back-to-back pulses allowed while pending drains.
- des_ready low: pulses held in pend_cnt; first pulse in the cycle after the edge where des_ready is sampled high.
- Source must keep events ≥ SYNC_STAGES+1 des_clk periods apart to guarantee detection; closer toggles may merge (TOGGLE mode loses even counts).
- Asynchronous reset mid-operation: all outputs 0 immediately; pending events discarded.

## Structure
- Package pluse_sync_pkg: edge_mode_e typedef, SYNC_STAGES_MIN = 2 constant.
- Sub-module sync_cell: single-bit SYNC_STAGES-deep synchronizer with async active-low reset to 0, instantiated CH times; edge detect, counter and issue logic stay in pluse_sync_rx within a generate loop.
- Elaboration-time assertion: SYNC_STAGES ≥ SYNC_STAGES_MIN, CNT_W ≥ 1, CH ≥ 1.

## Test plan
- Reset, des_ready=all 1, SYNC_STAGES=2, channel 0 s_evt 0→1 at des_clk edge 0 -> des_pluse[0] one cycle high after edge 2; pend_cnt 0; other channels silent.
- EDGE_TOGGLE, ch1 toggles 0→1→0 spaced 4 cycles -> two pulses 4 cycles apart; EDGE_RISE build -> one pulse; EDGE_FALL -> one pulse on the 1→0.
- des_ready[2]=0, three events spaced 4 cycles -> pend_cnt[2] reaches 3, no pulses; des_ready high -> three consecutive one-cycle pulses, pend_cnt 3→2→1→0.
- CNT_W=3, des_ready[3]=0, eight events -> pend_cnt saturates at 7, ovf[3]=1 on the 8th; ovf_clr[3] pulse -> ovf 0; ovf_clr coincident with an overflowing event -> ovf stays 1.
- pend_cnt=2, des_ready=1, new event in same cycle as issue -> pend_cnt unchanged that cycle, total pulses = 3.
- des_rstn low mid-drain with pend_cnt=5 -> des_pluse, pend_cnt, ovf all 0 immediately; after release no pulses without new events.
